mem_port_arbiter: RTL

Sequential arbiter that shares the single unified memory port of the pipelined RISC-V core between the instruction-fetch (IF) stage and the data-access (MEM) stage. It sits between the IF/MEM stage logic and the external memory. It issues one variable-latency memory transaction at a time over a req/ready handshake. It produces the global pipeline stall and per-port completion pulses, tracks which ports are already served in the current pipeline step, discards flushed fetches, and aborts hung transactions on timeout.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between instruction fetch (IF) and data access (MEM).
// One transaction at a time over a req/ready handshake. Data has priority over
// fetch because it belongs to the older instruction. Per-step served flags keep
// a completed port from being granted again until the pipeline advances.
// A flushed fetch still completes on the bus, but it is not delivered.
// Hung transactions are aborted after TIMEOUT wait cycles.
//
// Ports
//   clk, reset_n                  clock, synchronous active-low reset
//   if_req/if_addr/if_flush       fetch request side
//   if_rdata/if_valid             fetch completion (one-cycle pulse)
//   d_read/d_write/d_addr/
//   d_wdata/d_wstrb               data request side
//   d_rdata/d_valid               data completion (one-cycle pulse)
//   stall                         pipeline freeze (combinational)
//   bus_err                       pulses with the valid of a timed-out access
//   mem_*                         external memory port
//
// state  | meaning
// IDLE   | no transaction outstanding, mem_req low, grant decision made here
// BUSY_I | fetch transaction on the bus
// BUSY_D | data transaction on the bus
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                if_flush,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_valid,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_valid,
   output logic                stall,
   output logic                bus_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ready
);

   localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t     state;
   logic       d_served;
   logic       i_served;
   logic       discard;
   logic [7:0] tmr;
   logic       d_need;
   logic       i_need;
   logic       done;
   logic       expire;

   always_comb begin
      d_need = (d_read | d_write) & ~d_served;
      i_need = if_req & ~i_served & ~if_flush;
      stall  = d_need | i_need | (state == BUSY_D);
   end

   assign done   = mem_req & mem_ready;
   // The wait timer counts down from TIMEOUT; the last waiting cycle aborts.
   assign expire = mem_req & ~mem_ready & (tmr == 8'd1);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         d_served  <= 1'b0;
         i_served  <= 1'b0;
         discard   <= 1'b0;
         tmr       <= 8'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         if_valid  <= 1'b0;
         d_valid   <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         bus_err  <= 1'b0;

         if (!stall) begin
            d_served <= 1'b0;
            i_served <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (d_need) begin
                  state     <= BUSY_D;
                  mem_req   <= 1'b1;
                  mem_we    <= d_write;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  mem_wstrb <= d_write ? d_wstrb : '0;
                  tmr       <= TMR_LOAD;
               end else if (i_need) begin
                  state     <= BUSY_I;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
                  mem_wstrb <= '0;
                  tmr       <= TMR_LOAD;
                  discard   <= 1'b0;
               end
            end

            BUSY_D: begin
               if (done || expire) begin
                  state    <= IDLE;
                  mem_req  <= 1'b0;
                  d_rdata  <= done ? mem_rdata : '0;
                  d_valid  <= 1'b1;
                  bus_err  <= expire;
                  d_served <= 1'b1;
               end else if (!mem_ready) begin
                  tmr <= tmr - 8'd1;
               end
            end

            BUSY_I: begin
               if (if_flush)
                  discard <= 1'b1;
               if (done || expire) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  discard <= 1'b0;
                  // A flush in the completing cycle counts the same as an earlier one.
                  if (!(discard || if_flush)) begin
                     if_rdata <= done ? mem_rdata : '0;
                     if_valid <= 1'b1;
                     bus_err  <= expire;
                     i_served <= 1'b1;
                  end
               end else if (!mem_ready) begin
                  tmr <= tmr - 8'd1;
               end
            end

            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
